load_sequencer: RTL

Multi-cycle controller that sequences a MIPS-style load word (lw rt, imm(rs)) across the existing datapath.
- Register-file read of rs.
- Sign extension of imm.
- ALU add for the effective address.
- Data-memory read.
- Register-file writeback of rt.

It sits between the fetch/issue logic (start/done handshake) and the register_file, sign_extender, alu and data_memory blocks. It owns every control strobe on those blocks.

---
 rtl/load_seq_pkg.sv | 29 ++
 rtl/latency_counter.sv | 28 ++
 rtl/load_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/load_seq_pkg.sv
// Shared definitions for the lw sequencer: state encoding, ALU op codes,
// default load opcode and instruction field positions.
package load_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    ADDR   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOP = 3'b000;

  localparam logic [5:0] LW_OPCODE_DEFAULT = 6'b100011;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int IMM_LSB    = 0;
  localparam int REG_IDX_W  = 5;
  localparam int IMM_W      = 16;

  function automatic logic [5:0] opcodeOf(input logic [31:0] instr);
    return instr[OPCODE_LSB +: 6];
  endfunction

endpackage

// File: rtl/latency_counter.sv
// Down-counter for fixed-latency waits: load a start value, count down while
// enabled, expire reads high once the count has reached zero.
module latency_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadValue,
  input  logic             i_count,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (i_count && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_expire = (r_count == '0);

endmodule

// File: rtl/load_sequencer.sv
// Multi-cycle lw controller: IDLE -> DECODE -> ADDR -> MEM -> WB.
// Defining LOAD_SEQ_ALIGN_CHECK_EN adds o_misaligned and aborts unaligned loads.
module load_sequencer
  import load_seq_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [5:0]  LW_OPCODE   = LW_OPCODE_DEFAULT,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [31:0]       i_instr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_illegal,
  output logic [4:0]        o_read_reg1,
  output logic [4:0]        o_write_reg,
  output logic [15:0]       o_imm,
  output logic [2:0]        o_alu_control,
  input  logic [ADDR_W-1:0] i_alu_result,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_mem_read,
  input  logic [31:0]       i_mem_rdata,
`ifdef LOAD_SEQ_ALIGN_CHECK_EN
  output logic              o_misaligned,
`endif
  output logic              o_reg_write,
  output logic [31:0]       o_write_data
);

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

  state_t              r_state, w_nextState;
  logic [4:0]          r_readReg1, r_writeReg;
  logic [15:0]         r_imm;
  logic [ADDR_W-1:0]   r_address;
  logic [31:0]         r_writeData;
  logic                r_illegal;
  logic                w_accept, w_illegalHit, w_loadCount, w_expire;
  logic                w_misalignedHit, w_skipWrite;

  latency_counter #(.WIDTH(4)) u_memWait (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_loadCount),
    .i_loadValue (LAT_LOAD),
    .i_count     (r_state == MEM),
    .o_expire    (w_expire)
  );

`ifdef LOAD_SEQ_ALIGN_CHECK_EN
  logic r_misaligned;
  assign w_misalignedHit = (i_alu_result[1:0] != 2'b00);
  assign w_skipWrite     = r_misaligned;
  assign o_misaligned    = (r_state == WB) && r_misaligned;
`else
  assign w_misalignedHit = 1'b0;
  assign w_skipWrite     = 1'b0;
`endif

  always_comb begin
    w_nextState  = r_state;
    w_accept     = 1'b0;
    w_illegalHit = 1'b0;
    w_loadCount  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          if (opcodeOf(i_instr) == LW_OPCODE) begin
            w_accept    = 1'b1;
            w_nextState = DECODE;
          end else begin
            w_illegalHit = 1'b1;
          end
        end
      end
      DECODE: w_nextState = ADDR;
      ADDR: begin
        w_loadCount = 1'b1;
        w_nextState = w_misalignedHit ? WB : MEM;
      end
      MEM:     if (w_expire) w_nextState = WB;
      WB:      w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Fields, address and load data hold until overwritten by the next load.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_readReg1  <= '0;
      r_writeReg  <= '0;
      r_imm       <= '0;
      r_address   <= '0;
      r_writeData <= '0;
      r_illegal   <= 1'b0;
`ifdef LOAD_SEQ_ALIGN_CHECK_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
      r_state   <= w_nextState;
      r_illegal <= w_illegalHit;
      if (w_accept) begin
        r_readReg1 <= i_instr[RS_LSB +: REG_IDX_W];
        r_writeReg <= i_instr[RT_LSB +: REG_IDX_W];
        r_imm      <= i_instr[IMM_LSB +: IMM_W];
      end
      if (r_state == ADDR) begin
        r_address <= i_alu_result;
`ifdef LOAD_SEQ_ALIGN_CHECK_EN
        r_misaligned <= w_misalignedHit;
`endif
      end
      if ((r_state == MEM) && w_expire) r_writeData <= i_mem_rdata;
    end
  end

  assign o_busy        = (r_state != IDLE);
  assign o_done        = (r_state == WB);
  assign o_illegal     = r_illegal;
  assign o_read_reg1   = r_readReg1;
  assign o_write_reg   = r_writeReg;
  assign o_imm         = r_imm;
  assign o_alu_control = (r_state == ADDR) ? ALU_ADD : ALU_NOP;
  assign o_address     = r_address;
  assign o_mem_read    = (r_state == MEM);
  assign o_reg_write   = (r_state == WB) && !w_skipWrite;
  assign o_write_data  = r_writeData;

endmodule
